// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and SPI mode edge-select helpers for spi_slave_fifo
package spi_slave_pkg;

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Sampling happens on the rising SCLK edge exactly when CPOL equals CPHA
    function automatic logic sample_on_rise(spi_mode_t m);
        return m.cpol == m.cpha;
    endfunction

    function automatic logic shift_on_rise(spi_mode_t m);
        return m.cpol != m.cpha;
    endfunction

endpackage

// File: rtl/spi_slave_tx_fifo.sv
// spi_slave_tx_fifo: synchronous TX FIFO; a push while full is accepted only when a pop frees a slot that cycle
module spi_slave_tx_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr;
    logic [AW-1:0] rd;
    logic          accept;

    assign accept = push && (!full || pop);
    assign full   = level == (AW+1)'(DEPTH);
    assign empty  = level == '0;
    assign dout   = mem[rd];

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk)
        if (accept)
            mem[wr] <= din;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr       <= '0;
            rd       <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            wr       <= wr + AW'(accept);
            rd       <= rd + AW'(pop);
            level    <= level + (AW+1)'(accept) - (AW+1)'(pop);
            overflow <= push && !accept;
        end

endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: oversampled SPI slave streaming queued TX words; RX path enabled by SPI_SLAVE_RX_EN
module spi_slave_fifo
    import spi_slave_pkg::*;
#(
    parameter int   DATA_W     = 32,
    parameter int   FIFO_DEPTH = 8,
    parameter logic CPOL       = 1'b0,
    parameter logic CPHA       = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          SCLK,
    input  logic                          CS_n,
    input  logic                          MOSI,
    output logic                          MISO,
    input  logic                          data_valid,
    input  logic [DATA_W-1:0]             data_in,
    output logic                          tx_full,
    output logic                          tx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_overflow,
    output logic                          tx_underrun,
    output logic                          rx_valid,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          busy
);

    localparam int        CW     = $clog2(DATA_W + 1);
    localparam spi_mode_t MODE   = '{cpol: CPOL, cpha: CPHA};
    localparam logic      S_RISE = sample_on_rise(MODE);

    logic [1:0]        sclk_s;
    logic [1:0]        cs_s;
    logic              sclk_d;
    logic              cs_d;
    logic [1:0]        primed;
    logic              armed;
    logic              cs_fall;
    logic              cs_rise;
    logic              sample;
    logic              shift;
    state_t            state;
    state_t            state_nx;
    logic              word_done;
    logic              load;
    logic              pop;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] head;

    spi_slave_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (data_valid),
        .pop      (pop),
        .din      (data_in),
        .dout     (head),
        .full     (tx_full),
        .empty    (tx_empty),
        .level    (tx_level),
        .overflow (tx_overflow)
    );

    // Synchronisers and edge registers; armed blocks a CS_n fall until CS_n has been seen high after reset
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sclk_s <= {2{CPOL}};
            cs_s   <= 2'b11;
            sclk_d <= CPOL;
            cs_d   <= 1'b1;
            primed <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], SCLK};
            cs_s   <= {cs_s[0], CS_n};
            sclk_d <= sclk_s[1];
            cs_d   <= cs_s[1];
            primed <= {primed[0], 1'b1};
            armed  <= armed | (primed[1] & cs_s[1]);
        end

    assign cs_fall = armed & cs_d & ~cs_s[1];
    assign cs_rise = ~cs_d & cs_s[1];
    assign sample  = S_RISE ? (sclk_s[1] & ~sclk_d) : (~sclk_s[1] & sclk_d);
    assign shift   = S_RISE ? (~sclk_s[1] & sclk_d) : (sclk_s[1] & ~sclk_d);
    assign busy    = ~cs_s[1];

    // State register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;

    // Next state: frame boundaries follow the synchronised chip select
    always_comb
        state_nx = (state == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_rise ? IDLE : ACTIVE);

    // FSM outputs: a word is loaded at frame start and after each completed word
    always_comb begin
        word_done = (state == ACTIVE) && (bit_cnt == CW'(DATA_W));
        load      = ((state == IDLE) && cs_fall) || (word_done && !cs_rise);
        pop       = load && !tx_empty;
    end

    // TX shifter, bit counter, underrun pulse and registered MISO
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            tx_sr       <= '0;
            bit_cnt     <= '0;
            tx_underrun <= 1'b0;
            MISO        <= 1'b0;
        end else begin
            tx_underrun <= load && tx_empty;
            MISO        <= (state == ACTIVE) ? tx_sr[DATA_W-1] : 1'b0;
            if (load)
                tx_sr <= tx_empty ? '0 : head;
            else if (state == ACTIVE && shift && bit_cnt != '0)
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            if (state == IDLE || cs_rise || word_done)
                bit_cnt <= '0;
            else if (sample)
                bit_cnt <= bit_cnt + CW'(1);
        end

`ifdef SPI_SLAVE_RX_EN
    logic [1:0]        mosi_s;
    logic [DATA_W-1:0] rx_sr;

    // MOSI synchroniser and RX shifter; a partial word is simply overwritten by the next frame
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mosi_s   <= 2'b00;
            rx_sr    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            mosi_s   <= {mosi_s[0], MOSI};
            rx_valid <= word_done;
            if (state == ACTIVE && sample)
                rx_sr <= {rx_sr[DATA_W-2:0], mosi_s[1]};
            if (word_done)
                rx_data <= rx_sr;
        end
`else
    logic unused_mosi;

    assign unused_mosi = MOSI;
    assign rx_valid    = 1'b0;
    assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: directed checks on three spi_slave_fifo configurations (mode 0/32b, mode 3/16b depth 4, mode 1/32b)
module tb_spi_slave_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk [3];
    logic        cs_n [3];
    logic        mosi [3];
    logic        miso [3];
    logic        dv [3];
    logic        full [3];
    logic        empty [3];
    logic        ovf [3];
    logic        und [3];
    logic        rxv [3];
    logic        busy [3];
    logic [31:0] din_a;
    logic [15:0] din_b;
    logic [31:0] din_c;
    logic [3:0]  lvl_a;
    logic [2:0]  lvl_b;
    logic [3:0]  lvl_c;
    logic [31:0] rxd_a;
    logic [15:0] rxd_b;
    logic [31:0] rxd_c;

    bit cpol [3] = '{1'b0, 1'b1, 1'b0};
    bit cpha [3] = '{1'b0, 1'b1, 1'b1};

    int checks = 0;
    int errors = 0;
    int und_cnt [3] = '{0, 0, 0};
    int ovf_cnt [3] = '{0, 0, 0};
    int rxv_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    spi_slave_fifo u_a (
        .clk(clk), .reset_n(reset_n), .SCLK(sclk[0]), .CS_n(cs_n[0]), .MOSI(mosi[0]), .MISO(miso[0]),
        .data_valid(dv[0]), .data_in(din_a), .tx_full(full[0]), .tx_empty(empty[0]), .tx_level(lvl_a),
        .tx_overflow(ovf[0]), .tx_underrun(und[0]), .rx_valid(rxv[0]), .rx_data(rxd_a), .busy(busy[0])
    );

    spi_slave_fifo #(.DATA_W(16), .FIFO_DEPTH(4), .CPOL(1'b1), .CPHA(1'b1)) u_b (
        .clk(clk), .reset_n(reset_n), .SCLK(sclk[1]), .CS_n(cs_n[1]), .MOSI(mosi[1]), .MISO(miso[1]),
        .data_valid(dv[1]), .data_in(din_b), .tx_full(full[1]), .tx_empty(empty[1]), .tx_level(lvl_b),
        .tx_overflow(ovf[1]), .tx_underrun(und[1]), .rx_valid(rxv[1]), .rx_data(rxd_b), .busy(busy[1])
    );

    spi_slave_fifo #(.CPOL(1'b0), .CPHA(1'b1)) u_c (
        .clk(clk), .reset_n(reset_n), .SCLK(sclk[2]), .CS_n(cs_n[2]), .MOSI(mosi[2]), .MISO(miso[2]),
        .data_valid(dv[2]), .data_in(din_c), .tx_full(full[2]), .tx_empty(empty[2]), .tx_level(lvl_c),
        .tx_overflow(ovf[2]), .tx_underrun(und[2]), .rx_valid(rxv[2]), .rx_data(rxd_c), .busy(busy[2])
    );

    // Pulse counters, sampled on the inactive clock edge
    always @(negedge clk)
        for (int k = 0; k < 3; k++) begin
            und_cnt[k] += int'(und[k]);
            ovf_cnt[k] += int'(ovf[k]);
            rxv_cnt[k] += int'(rxv[k]);
        end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] lvl(input int d);
        return (d == 0) ? lvl_a : (d == 1) ? {1'b0, lvl_b} : lvl_c;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input int d, input logic [31:0] w);
        case (d)
            0: din_a = w;
            1: din_b = w[15:0];
            default: din_c = w;
        endcase
        dv[d] = 1'b1;
        wait_n(1);
        dv[d] = 1'b0;
    endtask

    task automatic start(input int d);
        cs_n[d] = 1'b0;
        wait_n(6);
        check($sformatf("busy_in_frame%0d", d), busy[d], 1'b1);
    endtask

    task automatic stop(input int d);
        wait_n(5);
        cs_n[d] = 1'b1;
        wait_n(6);
        check($sformatf("busy_after_frame%0d", d), busy[d], 1'b0);
        check($sformatf("miso_idle%0d", d), miso[d], 1'b0);
    endtask

    // Master bit engine: MOSI is set on the shift edge, MISO read at the sample edge
    task automatic bits(input int d, input int n, input logic [63:0] mo, output logic [63:0] mi);
        mi = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!cpha[d]) begin
                mosi[d] = mo[i];
                wait_n(5);
                mi = {mi[62:0], miso[d]};
                sclk[d] = ~cpol[d];
                wait_n(5);
                sclk[d] = cpol[d];
            end else begin
                sclk[d] = ~cpol[d];
                mosi[d] = mo[i];
                wait_n(5);
                mi = {mi[62:0], miso[d]};
                sclk[d] = cpol[d];
                wait_n(5);
            end
        end
    endtask

    typedef struct {
        logic        dv;
        logic [15:0] din;
        logic        full;
        logic        empty;
        logic [2:0]  lvl;
        logic        ovf;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [63:0] rd;
        int          u0;
        int          r0;
        tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[1] = '{1'b1, 16'hABCD, 1'b0, 1'b0, 3'd2, 1'b0};
        tbl[2] = '{1'b1, 16'h5A5A, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[3] = '{1'b1, 16'h0F0F, 1'b1, 1'b0, 3'd4, 1'b0};
        tbl[4] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 3'd4, 1'b1};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 1'b0};
        for (int d = 0; d < 3; d++) begin
            sclk[d] = cpol[d];
            cs_n[d] = 1'b1;
            mosi[d] = 1'b0;
            dv[d]   = 1'b0;
        end
        din_a = '0;
        din_b = '0;
        din_c = '0;
        wait_n(3);
        reset_n = 1'b1;
        wait_n(3);

        check("rst_miso", miso[0], 1'b0);
        check("rst_empty", empty[0], 1'b1);
        check("rst_full", full[0], 1'b0);
        check("rst_level", lvl_a, 4'd0);
        check("rst_overflow", ovf[0], 1'b0);
        check("rst_underrun", und[0], 1'b0);
        check("rst_rx_valid", rxv[0], 1'b0);
        check("rst_rx_data", rxd_a, 32'h0);
        check("rst_busy", busy[0], 1'b0);

        // Mode 0: single word out, level 1 -> 0, trailing reload from the empty FIFO underruns
        push_word(0, 32'hDEADBEEF);
        check("m0_level_after_write", lvl(0), 4'd1);
        u0 = und_cnt[0];
        start(0);
        bits(0, 32, 64'h0, rd);
        stop(0);
        check("m0_word", rd[31:0], 32'hDEADBEEF);
        check("m0_level_after_frame", lvl(0), 4'd0);
        check("m0_underrun_end_reload", und_cnt[0] - u0, 1);

        // Empty FIFO frame cut mid-word: zeros out, one underrun
        u0 = und_cnt[0];
        start(0);
        bits(0, 16, 64'h0, rd);
        stop(0);
        check("empty_frame_data", rd[15:0], 16'h0);
        check("empty_frame_underrun", und_cnt[0] - u0, 1);

        // Depth-4 FIFO fill table: fifth write dropped with one overflow pulse
        for (int i = 0; i < 6; i++) begin
            din_b = tbl[i].din;
            dv[1] = tbl[i].dv;
            wait_n(1);
            dv[1] = 1'b0;
            check($sformatf("tbl%0d_full", i), full[1], tbl[i].full);
            check($sformatf("tbl%0d_empty", i), empty[1], tbl[i].empty);
            check($sformatf("tbl%0d_level", i), lvl_b, tbl[i].lvl);
            check($sformatf("tbl%0d_overflow", i), ovf[1], tbl[i].ovf);
        end
        check("tbl_overflow_count", ovf_cnt[1], 1);

        // Push while full in the same cycle as the frame-start pop: accepted, level unchanged
        cs_n[1] = 1'b0;
        wait_n(2);
        din_b = 16'h7777;
        dv[1] = 1'b1;
        wait_n(1);
        dv[1] = 1'b0;
        check("pushpop_level", lvl_b, 3'd4);
        check("pushpop_no_overflow", ovf_cnt[1], 1);
        wait_n(3);
        u0 = und_cnt[1];
        bits(1, 64, 64'h0, rd);
        check("fifo_readback", rd, 64'h1234ABCD5A5A0F0F);
        check("readback_no_underrun", und_cnt[1] - u0, 0);
        bits(1, 16, 64'h0, rd);
        stop(1);
        check("pushpop_word", rd[15:0], 16'h7777);
        check("readback_level", lvl_b, 3'd0);

        // Mode 3 back-to-back words; the spare third word keeps the reload from underrunning
        push_word(1, 32'h1234);
        push_word(1, 32'hABCD);
        push_word(1, 32'h1111);
        u0 = und_cnt[1];
        start(1);
        bits(1, 32, 64'h0, rd);
        stop(1);
        check("m3_two_words", rd[31:0], 32'h1234ABCD);
        check("m3_no_underrun", und_cnt[1] - u0, 0);
        check("m3_popped_word_lost", lvl_b, 3'd0);

        // Mode 1: TX word out while MOSI streams in
        push_word(2, 32'h13579BDF);
        r0 = rxv_cnt[2];
        start(2);
        bits(2, 32, 64'hA5A50F0F, rd);
        stop(2);
        check("m1_tx_word", rd[31:0], 32'h13579BDF);
`ifdef SPI_SLAVE_RX_EN
        check("m1_rx_valid_count", rxv_cnt[2] - r0, 1);
        check("m1_rx_data", rxd_c, 32'hA5A50F0F);
`else
        check("m1_rx_valid_tied", rxv_cnt[2] - r0, 0);
        check("m1_rx_data_tied", rxd_c, 32'h0);
`endif
        r0 = rxv_cnt[2];
        start(2);
        bits(2, 10, 64'h3FF, rd);
        stop(2);
        check("partial_no_rx_valid", rxv_cnt[2] - r0, 0);
`ifdef SPI_SLAVE_RX_EN
        check("partial_rx_data_kept", rxd_c, 32'hA5A50F0F);
`else
        check("partial_rx_data_tied", rxd_c, 32'h0);
`endif

        // Reset mid-frame with three words queued
        push_word(0, 32'h11111111);
        push_word(0, 32'h22222222);
        push_word(0, 32'h33333333);
        check("pre_reset_level", lvl(0), 4'd3);
        start(0);
        bits(0, 8, 64'h0, rd);
        check("pre_reset_bits", rd[7:0], 8'h11);
        reset_n = 1'b0;
        #1;
        check("midrst_miso", miso[0], 1'b0);
        check("midrst_empty", empty[0], 1'b1);
        check("midrst_level", lvl_a, 4'd0);
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_underrun", und[0], 1'b0);
        wait_n(1);
        reset_n = 1'b1;
        u0 = und_cnt[0];
        bits(0, 24, 64'h0, rd);
        stop(0);
        check("rest_of_frame_ignored", rd[23:0], 24'h0);
        check("rest_no_underrun", und_cnt[0] - u0, 0);
        start(0);
        bits(0, 16, 64'h0, rd);
        stop(0);
        check("post_reset_zeros", rd[15:0], 16'h0);
        check("post_reset_underrun", und_cnt[0] - u0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
